// File: rtl/mdu_ctrl_pkg.sv
// ============================================================================
// Module      : mdu_ctrl_pkg
// Description : Shared CPU defines for the multiply/divide unit: op encoding,
//               controller states and an operand-magnitude helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IsNone   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_e;

    function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_ctrl_if.sv
// ============================================================================
// Module      : mdu_ctrl_if
// Description : EXE-stage issue bus and result bus of the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_ctrl_if;
    logic [2:0]  EXE_MDU_Op;
    logic [31:0] EXE_Src_A;
    logic [31:0] EXE_Src_B;
    logic        MDU_Flush;
    logic        MDU_Hold;
    logic        MDU_Busy;
    logic [31:0] MDU_Hi;
    logic [31:0] MDU_Lo;
    logic        MDU_Done;

    modport master (
        output EXE_MDU_Op, EXE_Src_A, EXE_Src_B, MDU_Flush, MDU_Hold,
        input  MDU_Busy, MDU_Hi, MDU_Lo, MDU_Done
    );

    modport slave (
        input  EXE_MDU_Op, EXE_Src_A, EXE_Src_B, MDU_Flush, MDU_Hold,
        output MDU_Busy, MDU_Hi, MDU_Lo, MDU_Done
    );
endinterface

`default_nettype wire

// File: rtl/div_radix2.sv
// ============================================================================
// Module      : div_radix2
// Description : Unsigned radix-2 restoring divider, one quotient bit per step.
//               Outputs are the post-step values so the caller can capture the
//               final result on the same edge as the last step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_radix2 (
    input  wire logic        clk,
    input  wire logic        resetn,
    input  wire logic        load_i,
    input  wire logic        step_i,
    input  wire logic [31:0] dividend_i,
    input  wire logic [31:0] divisor_i,
    output logic      [31:0] quo_nxt_o,
    output logic      [31:0] rem_nxt_o,
    output logic             last_o
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [5:0]  cnt_q;

    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_ge;

    // Partial remainder stays below the divisor, so bit 32 of the trial is a sign bit.
    assign w_shift   = {rem_q, quo_q[31]};
    assign w_trial   = w_shift - {1'b0, dvs_q};
    assign w_ge      = ~w_trial[32];
    assign rem_nxt_o = w_ge ? w_trial[31:0] : w_shift[31:0];
    assign quo_nxt_o = {quo_q[30:0], w_ge};
    assign last_o    = step_i && (cnt_q == 6'd31);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= '0;
        end else if (step_i) begin
            rem_q <= rem_nxt_o;
            quo_q <= quo_nxt_o;
            cnt_q <= cnt_q + 6'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module      : mdu_ctrl
// Description : Multiply/divide controller: single-cycle multiply, 32-step
//               divide, Hi/Lo result registers and pipeline stall handshake.
//               Optional feature macro: DIV_EARLY_OUT_EN (divide early-out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   resetn,
    mdu_ctrl_if.slave   bus
);

    mdu_state_e  state_q, state_d;
    logic [31:0] a_q, b_q;
    logic        sgn_q;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        w_is_mul, w_is_div, w_op_sgn, w_start;
    logic [31:0] w_mag_a, w_mag_b;
    logic [63:0] w_prod;
    logic [31:0] w_q_mag, w_r_mag, w_div_hi, w_div_lo;
    logic        w_div_last, w_q_neg, w_r_neg;

    assign w_is_mul = (bus.EXE_MDU_Op == OP_MULT) || (bus.EXE_MDU_Op == OP_MULTU);
    assign w_is_div = (bus.EXE_MDU_Op == OP_DIV)  || (bus.EXE_MDU_Op == OP_DIVU);
    assign w_op_sgn = (bus.EXE_MDU_Op == OP_MULT) || (bus.EXE_MDU_Op == OP_DIV);
    assign w_start  = (state_q == S_IDLE) && (w_is_mul || w_is_div)
                      && !bus.MDU_Flush && !bus.MDU_Hold;

    assign w_mag_a  = mag32(bus.EXE_Src_A, w_op_sgn);
    assign w_mag_b  = mag32(bus.EXE_Src_B, w_op_sgn);

    // Sign-extending to 64 bits makes one multiplier serve both MULT and MULTU.
    assign w_prod   = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

    div_radix2 u_div (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (w_start && w_is_div),
        .step_i     (state_q == S_DIV),
        .dividend_i (w_mag_a),
        .divisor_i  (w_mag_b),
        .quo_nxt_o  (w_q_mag),
        .rem_nxt_o  (w_r_mag),
        .last_o     (w_div_last)
    );

    assign w_q_neg  = sgn_q && (a_q[31] ^ b_q[31]);
    assign w_r_neg  = sgn_q && a_q[31];
    assign w_div_lo = (b_q == '0) ? '1  : (w_q_neg ? (~w_q_mag + 32'd1) : w_q_mag);
    assign w_div_hi = (b_q == '0) ? a_q : (w_r_neg ? (~w_r_mag + 32'd1) : w_r_mag);

`ifdef DIV_EARLY_OUT_EN
    logic w_early;
    assign w_early = (w_mag_b == '0) || (w_mag_a < w_mag_b);
`endif

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    if (w_is_mul) begin
                        state_d = S_MUL;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (w_early) begin
                        state_d = S_DONE;
                        hi_d    = bus.EXE_Src_A;
                        lo_d    = (w_mag_b == '0) ? '1 : '0;
                    end
`endif
                    else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                state_d = S_DONE;
                hi_d    = w_prod[63:32];
                lo_d    = w_prod[31:0];
            end
            S_DIV: begin
                if (w_div_last) begin
                    state_d = S_DONE;
                    hi_d    = w_div_hi;
                    lo_d    = w_div_lo;
                end
            end
            S_DONE: begin
                if (!bus.MDU_Hold) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A flush abandons whatever is in flight without touching Hi/Lo.
        if (bus.MDU_Flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (w_start) begin
                a_q   <= bus.EXE_Src_A;
                b_q   <= bus.EXE_Src_B;
                sgn_q <= w_op_sgn;
            end
        end
    end

    assign bus.MDU_Busy = !bus.MDU_Flush &&
                          (w_start || (state_q == S_MUL) || (state_q == S_DIV));
    assign bus.MDU_Done = !bus.MDU_Flush && (state_q == S_DONE);
    assign bus.MDU_Hi   = hi_q;
    assign bus.MDU_Lo   = lo_q;

endmodule

`default_nettype wire
